// File: rtl/pipelined_fetch_unit.sv
// Pipelined instruction fetch unit.
// Issues sequential word reads from fpc, buffers {pc, inst} pairs in a small
// FIFO and presents the head to decode with a valid/ready handshake.
// A redirect flushes the buffer and restarts fetch at the new target. A read
// may only issue while the FIFO has room for it, counting the read that is
// already in flight.
module pipelined_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign_err
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] pend_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            pending;
    logic            kill;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            issue;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    // Credits are taken from registered state only, so a pop in the same
    // cycle cannot make room for an extra read.
    assign occupancy = count + CW'(pending);
    assign issue     = !reset && !redirect_valid && (occupancy < DEPTH_C);

    // A redirect cycle drops both the arriving response and any handshake.
    assign push      = pending && !kill && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign imem_en      = issue;
    assign imem_addr    = fpc;
    assign out_valid    = !reset && (count != '0);
    assign out_pc       = pc_mem[rd_ptr];
    assign out_inst     = inst_mem[rd_ptr];
    assign misalign_err = !reset && redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Fetch PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc     <= {RESET_PC[XLEN-1:2], 2'b00};
            pend_pc <= '0;
            pending <= 1'b0;
            kill    <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (redirect_valid) begin
            fpc     <= {redirect_pc[XLEN-1:2], 2'b00};
            kill    <= pending;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            pending <= issue;
            kill    <= 1'b0;
            if (issue) begin
                pend_pc <= fpc;
                fpc     <= fpc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]   <= pend_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Bench for pipelined_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_pipelined_fetch_unit;

    localparam int              XLEN     = 64;
    localparam int              DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Word at address a: addi x(idx), x0, idx  (0x00000013, 0x00100093, ...)
    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] idx;
        idx = a >> 2;
        return 32'h13 | ({27'd0, idx[4:0]} << 7) | ({20'd0, idx[11:0]} << 20);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: data valid the cycle after the strobe, junk otherwise.
    logic            lat_en = 1'b0;
    logic [XLEN-1:0] lat_addr = '0;
    always @(negedge clk) begin
        lat_en   <= imem_en;
        lat_addr <= imem_addr;
    end
    always @(posedge clk) begin
        imem_rdata <= lat_en ? mem_word(lat_addr) : $urandom();
    end

    // Reference model: fetch PC, queue of buffered entries, one in-flight read.
    initial begin : model
        logic [XLEN-1:0] m_fpc;
        logic [XLEN-1:0] m_pend_pc;
        logic            m_pend;
        logic            m_kill;
        logic [XLEN-1:0] q_pc[$];
        logic [31:0]     q_inst[$];
        logic            e_en, e_valid, e_mis;
        m_fpc     = RESET_PC;
        m_pend_pc = '0;
        m_pend    = 1'b0;
        m_kill    = 1'b0;
        forever begin
            @(negedge clk);
            e_en    = !reset && !redirect_valid && ((q_pc.size() + int'(m_pend)) < DEPTH);
            e_valid = !reset && (q_pc.size() != 0);
            e_mis   = !reset && redirect_valid && (redirect_pc[1:0] != 2'b00);
            check("m_imem_en", imem_en, e_en);
            if (e_en) check("m_imem_addr", imem_addr, m_fpc);
            check("m_out_valid", out_valid, e_valid);
            if (e_valid) begin
                check("m_out_pc", out_pc, q_pc[0]);
                check("m_out_inst", out_inst, q_inst[0]);
            end
            check("m_misalign", misalign_err, e_mis);
            if (reset) begin
                m_fpc  = RESET_PC;
                m_pend = 1'b0;
                m_kill = 1'b0;
                q_pc.delete();
                q_inst.delete();
            end else if (redirect_valid) begin
                m_fpc  = {redirect_pc[XLEN-1:2], 2'b00};
                m_kill = m_pend;
                m_pend = 1'b0;
                q_pc.delete();
                q_inst.delete();
            end else begin
                if (e_valid && out_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (m_pend && !m_kill) begin
                    q_pc.push_back(m_pend_pc);
                    q_inst.push_back(mem_word(m_pend_pc));
                end
                m_kill = 1'b0;
                m_pend = e_en;
                if (e_en) begin
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 64'd4;
                end
            end
        end
    end

    // Drive one cycle of inputs just after the edge; return mid-cycle.
    task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [XLEN-1:0] t);
        @(posedge clk);
        #1;
        reset          = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = t;
        @(negedge clk);
    endtask

    initial begin : stim
        int issues;
        logic [63:0] exp_pc;

        // Reset, including a misaligned redirect while reset is high.
        cyc(1, 1, 0, 0);
        check("lit_rst_en", imem_en, 0);
        check("lit_rst_valid", out_valid, 0);
        check("lit_rst_mis", misalign_err, 0);
        cyc(1, 1, 1, 64'h102);
        check("lit_rst_redir_mis", misalign_err, 0);
        check("lit_rst_redir_en", imem_en, 0);

        // Streaming after reset release.
        cyc(0, 1, 0, 0);
        check("lit_c0_en", imem_en, 1);
        check("lit_c0_addr", imem_addr, 64'h0);
        check("lit_c0_valid", out_valid, 0);
        cyc(0, 1, 0, 0);
        check("lit_c1_addr", imem_addr, 64'h4);
        check("lit_c1_valid", out_valid, 0);
        cyc(0, 1, 0, 0);
        check("lit_c2_addr", imem_addr, 64'h8);
        check("lit_c2_valid", out_valid, 1);
        check("lit_c2_pc", out_pc, 64'h0);
        check("lit_c2_inst", out_inst, 32'h00000013);
        cyc(0, 1, 0, 0);
        check("lit_c3_pc", out_pc, 64'h4);
        check("lit_c3_inst", out_inst, 32'h00100093);
        cyc(0, 1, 0, 0);
        check("lit_c4_pc", out_pc, 64'h8);

        // Stall with decode not ready: credits cap the issues at DEPTH.
        cyc(1, 0, 0, 0);
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            if (imem_en) issues++;
        end
        check("lit_stall_issues", issues, 4);
        check("lit_stall_valid", out_valid, 1);
        check("lit_stall_pc", out_pc, 64'h0);
        exp_pc = 64'h0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            check("lit_drain_pc", out_pc, exp_pc);
            exp_pc = exp_pc + 64'd4;
        end

        // Redirect with 3 buffered entries and a read in flight.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 64'h100);
        check("lit_fl_redir_en", imem_en, 0);
        check("lit_fl_before_valid", out_valid, 1);
        cyc(0, 1, 0, 0);
        check("lit_fl_valid_t1", out_valid, 0);
        check("lit_fl_en_t1", imem_en, 1);
        check("lit_fl_addr_t1", imem_addr, 64'h100);
        cyc(0, 1, 0, 0);
        check("lit_fl_valid_t2", out_valid, 0);
        cyc(0, 1, 0, 0);
        check("lit_fl_valid_t3", out_valid, 1);
        check("lit_fl_pc_t3", out_pc, 64'h100);
        check("lit_fl_inst_t3", out_inst, 32'h04000013);
        cyc(0, 1, 0, 0);
        check("lit_fl_pc_t4", out_pc, 64'h104);

        // Back-to-back redirects: the last one wins.
        cyc(0, 1, 1, 64'h200);
        check("lit_b2b_en0", imem_en, 0);
        cyc(0, 1, 1, 64'h300);
        check("lit_b2b_en1", imem_en, 0);
        cyc(0, 1, 0, 0);
        check("lit_b2b_en2", imem_en, 1);
        check("lit_b2b_addr", imem_addr, 64'h300);
        cyc(0, 1, 0, 0);
        check("lit_b2b_valid", out_valid, 0);
        cyc(0, 1, 0, 0);
        check("lit_b2b_pc", out_pc, 64'h300);

        // Misaligned redirect.
        cyc(0, 1, 1, 64'h102);
        check("lit_mis_pulse", misalign_err, 1);
        cyc(0, 1, 0, 0);
        check("lit_mis_clear", misalign_err, 0);
        check("lit_mis_addr", imem_addr, 64'h100);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("lit_mis_pc", out_pc, 64'h100);

        // PC wrap at the top of the address space.
        cyc(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 1, 0, 0);
        check("lit_wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 1, 0, 0);
        check("lit_wrap_addr1", imem_addr, 64'h0);
        cyc(0, 1, 0, 0);
        check("lit_wrap_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 1, 0, 0);
        check("lit_wrap_pc1", out_pc, 64'h0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic            r, rdy, rv;
            logic [XLEN-1:0] t;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                1:       t = 64'($urandom_range(0, 4095));
                default: t = {$urandom(), $urandom()};
            endcase
            cyc(r, rdy, rv, t);
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_fetch_unit.md
PIPELINED_FETCH_UNIT -- requirements
Module: pipelined_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-buffer entries; legal values are powers of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-006 SHALL have port imem_en, output, 1 bit; instruction-memory read strobe.
REQ-007 SHALL have port imem_addr, output, XLEN bits; byte address of the read, with bits [1:0] always 0.
REQ-008 SHALL have port imem_rdata, input, 32 bits; read data, valid exactly one cycle after imem_en.
REQ-009 SHALL have port redirect_valid, input, 1 bit; branch/jump/flush request from decode.
REQ-010 SHALL have port redirect_pc, input, XLEN bits; new fetch target.
REQ-011 SHALL have port out_valid, output, 1 bit; the buffer head holds an instruction.
REQ-012 SHALL have port out_ready, input, 1 bit; decode accepts the head (stall = low).
REQ-013 SHALL have port out_inst, output, 32 bits; head instruction.
REQ-014 SHALL have port out_pc, output, XLEN bits; PC of the head instruction.
REQ-015 SHALL have port misalign_err, output, 1 bit; one-cycle pulse when redirect_pc[1:0] is nonzero.

Function
REQ-016 SHALL hold state in: fetch PC register fpc; a FIFO of DEPTH {pc, inst} entries; an occupancy count of 0..DEPTH; a pending flag for an outstanding read; a kill flag.
REQ-017 SHALL assert imem_en, with imem_addr = fpc, when (count + pending) < DEPTH and redirect_valid = 0, using registered values only; a pop in the same cycle does not free a credit.
REQ-018 SHALL increment fpc by 4 on each issue, wrapping modulo 2^XLEN.
REQ-019 SHALL set pending = 1 in the cycle after an issue; in that cycle it SHALL push {issued pc, imem_rdata} unless kill = 1.
REQ-020 SHALL define a pop as out_valid and out_ready both high; it removes the head.
REQ-021 SHALL keep count unchanged when a push and a pop occur in the same cycle; a full FIFO SHALL never be pushed, which the credit rule in REQ-017 guarantees.
REQ-022 SHALL drive out_valid = (count != 0); out_inst and out_pc SHALL be the head entry, and SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL, on redirect_valid, empty the FIFO (count set to 0, pointers reset), load fpc = {redirect_pc[XLEN-1:2], 2'b00}, and set kill = pending so a response in flight is discarded.
REQ-024 SHALL ignore any push and pop in a redirect cycle; redirect has priority.
REQ-025 SHALL, when redirect_valid is asserted in consecutive cycles, let the last target win, with no issue until redirect_valid is low.
REQ-026 SHALL clear kill one cycle after it is set.
REQ-027 SHALL have latency as follows: redirect at cycle t gives issue at t+1, push at t+2, and out_valid at t+3, given an empty FIFO and no stall.
REQ-028 SHALL sustain one instruction per cycle when out_ready is held high.
REQ-029 SHALL pulse misalign_err in the same cycle as a redirect whose redirect_pc[1:0] != 0.

Reset
REQ-030 SHALL, while reset = 1, set fpc = RESET_PC, count = 0, pending = 0, kill = 0, imem_en = 0, out_valid = 0 and misalign_err = 0.
REQ-031 SHALL give reset priority over redirect_valid and over any handshake.
REQ-032 SHALL discard a response whose read was issued in the cycle before reset was asserted.
REQ-033 SHALL issue the first fetch in the first cycle after reset deasserts, with imem_addr = RESET_PC.

Verification
REQ-034 Reset release with out_ready=1 and memory words 0x00000013, 0x00100093, ... -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; out_valid from cycle 2 with out_pc 0x0, 0x4, 0x8, one per cycle.
REQ-035 Hold out_ready=0 with DEPTH=4 -> exactly 4 issues, then imem_en=0; out_pc stays 0x0; after out_ready=1, out_pc 0x0..0xC drain in order and issuing resumes with no lost or duplicated PC.
REQ-036 Redirect to 0x100 while the FIFO holds 3 entries and a read is pending -> out_valid=0 next cycle; the pending word is dropped; next issue at 0x100; first out_pc=0x100 three cycles after the redirect.
REQ-037 Redirect to 0x200 then 0x300 in back-to-back cycles -> no issue at 0x200; first out_pc=0x300.
REQ-038 Redirect to 0x102 -> misalign_err pulses for one cycle and fetch proceeds from 0x100; redirect with reset high -> fetch restarts at RESET_PC and misalign_err=0.
REQ-039 Redirect to 2^XLEN-4 -> out_pc 0xFF..FC, then 0x0 (wrap).
